// File: rtl/i2s_rx_deserializer.sv
// I2S receive deserializer for the SPH0645 mic path: samples DOUT on BCLK rises,
// assembles one signed sample per LRCLK slot and hands it over a valid/ready port.
module i2s_rx_deserializer #(
    parameter int SAMPLE_BITS = 18,
    parameter int SLOT_BITS   = 32
) (
    input  logic                   clk_25m,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   bclk,
    input  logic                   lrclk,
    input  logic                   sdata,
    output logic [SAMPLE_BITS-1:0] sample_data,
    output logic                   sample_right,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic                   overrun,
    output logic                   frame_err,
    input  logic                   err_clr
);

    localparam int CW = $clog2(SLOT_BITS + 1);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] LAST_DATA = CW'(SAMPLE_BITS);
    localparam logic [CW-1:0] SLOT_END  = CW'(SLOT_BITS);

    typedef enum logic {
        SYNC,
        SHIFT
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   chan_q, chan_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d, shift_next;
    logic                   sd_meta, sdata_s;
    logic                   bclk_q, lr_prev;
    logic                   rise, slot_start, complete, frame_evt, slot_free;

    assign rise       = bclk & ~bclk_q;
    assign slot_start = rise & (lrclk != lr_prev);
    assign shift_next = (shift_q << 1) | SAMPLE_BITS'(sdata_s);
    assign slot_free  = ~sample_valid | sample_ready;

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            sd_meta <= 1'b0;
            sdata_s <= 1'b0;
            bclk_q  <= 1'b0;
            lr_prev <= 1'b0;
        end else begin
            sd_meta <= sdata;
            sdata_s <= sd_meta;
            bclk_q  <= bclk;
            if (rise) begin
                lr_prev <= lrclk;
            end
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SYNC;
            cnt_q   <= '0;
            chan_q  <= 1'b0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
            shift_q <= shift_d;
        end
    end

    // cnt holds the index of the next bit; a start rise is index 0 (the I2S delay bit)
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        chan_d    = chan_q;
        shift_d   = shift_q;
        complete  = 1'b0;
        frame_evt = 1'b0;
        if (!enable) begin
            state_d = SYNC;
            cnt_d   = '0;
        end else if (rise) begin
            case (state_q)
                SYNC: begin
                    if (slot_start) begin
                        state_d = SHIFT;
                        cnt_d   = ONE;
                        chan_d  = lrclk;
                    end
                end
                SHIFT: begin
                    if (slot_start) begin
                        frame_evt = (cnt_q <= LAST_DATA);
                        cnt_d     = ONE;
                        chan_d    = lrclk;
                    end else begin
                        cnt_d = cnt_q + ONE;
                        if (cnt_q >= ONE && cnt_q <= LAST_DATA) begin
                            shift_d  = shift_next;
                            complete = (cnt_q == LAST_DATA);
                        end else if (cnt_q == SLOT_END) begin
                            frame_evt = 1'b1;
                            state_d   = SYNC;
                            cnt_d     = '0;
                        end
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            sample_data  <= '0;
            sample_right <= 1'b0;
            sample_valid <= 1'b0;
        end else if (!enable) begin
            sample_valid <= 1'b0;
        end else if (complete && slot_free) begin
            sample_data  <= shift_next;
            sample_right <= chan_q;
            sample_valid <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    // error set takes priority over a coincident clear
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (complete && !slot_free) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
            if (frame_evt) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer: slot-level reference model checked every
// cycle, plus hand-computed expectations for latency, data, flags and reset.
module tb_i2s_rx_deserializer;

    localparam int SB   = 18;
    localparam int SLOT = 32;

    logic          clk_25m;
    logic          rst_n;
    logic          enable;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic [SB-1:0] sample_data;
    logic          sample_right;
    logic          sample_valid;
    logic          sample_ready;
    logic          overrun;
    logic          frame_err;
    logic          err_clr;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    i2s_rx_deserializer #(
        .SAMPLE_BITS(SB),
        .SLOT_BITS  (SLOT)
    ) dut (
        .clk_25m     (clk_25m),
        .rst_n       (rst_n),
        .enable      (enable),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .sample_data (sample_data),
        .sample_right(sample_right),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .err_clr     (err_clr)
    );

    initial clk_25m = 1'b0;
    always #20 clk_25m = ~clk_25m;

    // Reference model: tracks position within the current slot as a plain integer
    // and accumulates the sample arithmetically.
    bit          m_bclk_prev, m_lr_prev, m_in_slot, m_chan;
    bit          m_rise, m_start, m_done, m_fe;
    int          m_pos, m_acc;
    bit          exp_valid, exp_right, exp_ovr, exp_ferr;
    logic [SB-1:0] exp_data;

    always @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            m_bclk_prev = 0; m_lr_prev = 0; m_in_slot = 0; m_chan = 0;
            m_pos = 0; m_acc = 0;
            exp_valid = 0; exp_right = 0; exp_ovr = 0; exp_ferr = 0; exp_data = '0;
        end else begin
            m_done = 0;
            m_fe = 0;
            m_rise = bclk && !m_bclk_prev;
            m_bclk_prev = bclk;
            if (!enable) m_in_slot = 0;
            if (m_rise) begin
                m_start = (lrclk != m_lr_prev);
                m_lr_prev = lrclk;
                if (enable) begin
                    if (m_start) begin
                        if (m_in_slot && m_pos <= SB) m_fe = 1;
                        m_in_slot = 1;
                        m_pos = 1;
                        m_acc = 0;
                        m_chan = lrclk;
                    end else if (m_in_slot) begin
                        if (m_pos >= 1 && m_pos <= SB) begin
                            m_acc = m_acc * 2 + int'(sdata);
                            if (m_pos == SB) m_done = 1;
                        end else if (m_pos == SLOT) begin
                            m_fe = 1;
                            m_in_slot = 0;
                        end
                        m_pos++;
                    end
                end
            end
            if (err_clr) begin
                exp_ovr = 0;
                exp_ferr = 0;
            end
            if (m_fe) exp_ferr = 1;
            if (!enable) begin
                exp_valid = 0;
            end else if (m_done) begin
                if (!exp_valid || sample_ready) begin
                    exp_valid = 1;
                    exp_data = SB'(m_acc);
                    exp_right = m_chan;
                end else begin
                    exp_ovr = 1;
                end
            end else if (exp_valid && sample_ready) begin
                exp_valid = 0;
            end
        end
    end

    task automatic report(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_25m) begin
        if (chk_en) begin
            report("valid", 32'(sample_valid), 32'(exp_valid));
            report("overrun", 32'(overrun), 32'(exp_ovr));
            report("frame_err", 32'(frame_err), 32'(exp_ferr));
            if (exp_valid) begin
                report("data", 32'(sample_data), 32'(exp_data));
                report("right", 32'(sample_right), 32'(exp_right));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_25m);
            #2;
        end
    endtask

    // One slot of nbits BCLK periods; index 0 is the delay bit, 1..SB carry data MSB first.
    task automatic send_slot(input bit lr, input logic [SB-1:0] data, input int nbits, input bit chk);
        for (int i = 0; i < nbits; i++) begin
            bclk  = 1'b0;
            lrclk = lr;
            if (i == 0) sdata = 1'b0;
            else if (i <= SB) sdata = data[SB-i];
            else sdata = 1'b1;
            tick(4);
            bclk = 1'b1;
            if (chk && i == SB) begin
                report("lat_before", 32'(sample_valid), 32'd0);
                tick(1);
                report("lat_valid", 32'(sample_valid), 32'd1);
                report("lat_data", 32'(sample_data), 32'(data));
                report("lat_right", 32'(sample_right), 32'(lr));
                tick(3);
            end else begin
                tick(4);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        report({tag, "_valid"}, 32'(sample_valid), 32'd0);
        report({tag, "_data"}, 32'(sample_data), 32'd0);
        report({tag, "_right"}, 32'(sample_right), 32'd0);
        report({tag, "_ovr"}, 32'(overrun), 32'd0);
        report({tag, "_ferr"}, 32'(frame_err), 32'd0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    logic [SB-1:0] frames [4] = '{18'h0F0F0, 18'h35555, 18'h00000, 18'h3FFFE};

    initial begin
        rst_n = 1'b0; enable = 1'b1; bclk = 1'b0; lrclk = 1'b1; sdata = 1'b0;
        sample_ready = 1'b1; err_clr = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        chk_en = 1;
        tick(2);

        send_slot(1'b1, 18'h12345, SLOT, 1'b0);
        send_slot(1'b0, 18'h2A5A5, SLOT, 1'b1);
        send_slot(1'b1, 18'h20001, SLOT, 1'b1);
        for (int k = 0; k < 4; k++) send_slot(k[0], frames[k], SLOT, 1'b0);
        report("nominal_ovr", 32'(overrun), 32'd0);
        report("nominal_ferr", 32'(frame_err), 32'd0);

        sample_ready = 1'b0;
        send_slot(1'b0, 18'h00001, SLOT, 1'b0);
        send_slot(1'b1, 18'h3FFFF, SLOT, 1'b0);
        report("bp_valid", 32'(sample_valid), 32'd1);
        report("bp_data", 32'(sample_data), 32'h00001);
        report("bp_right", 32'(sample_right), 32'd0);
        report("bp_ovr", 32'(overrun), 32'd1);
        sample_ready = 1'b1;
        tick(1);
        sample_ready = 1'b0;
        tick(1);
        report("bp_drop", 32'(sample_valid), 32'd0);
        pulse_clr();
        report("bp_clr", 32'(overrun), 32'd0);
        sample_ready = 1'b1;

        send_slot(1'b0, 18'h11111, 10, 1'b0);
        send_slot(1'b1, 18'h2BCDE, SLOT, 1'b1);
        report("short_ferr", 32'(frame_err), 32'd1);
        pulse_clr();
        report("short_clr", 32'(frame_err), 32'd0);

        send_slot(1'b0, 18'h0AAAA, 40, 1'b0);
        report("long_ferr", 32'(frame_err), 32'd1);
        send_slot(1'b1, 18'h15555, SLOT, 1'b1);

        send_slot(1'b0, 18'h3C3C3, 9, 1'b0);
        bclk = 1'b0; lrclk = 1'b0; sdata = 1'b1;
        tick(2);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick(3);
        rst_n = 1'b1;
        tick(1);
        send_slot(1'b0, 18'h00000, SLOT - 9, 1'b0);
        send_slot(1'b1, 18'h1E1E1, SLOT, 1'b1);

        sample_ready = 1'b0;
        send_slot(1'b0, 18'h2468A, SLOT, 1'b0);
        send_slot(1'b1, 18'h13579, 10, 1'b0);
        send_slot(1'b0, 18'h3C3C3, 9, 1'b0);
        report("en_pending", 32'(sample_valid), 32'd1);
        bclk = 1'b0;
        enable = 1'b0;
        tick(2);
        report("en_valid_clr", 32'(sample_valid), 32'd0);
        report("en_ferr_kept", 32'(frame_err), 32'd1);
        enable = 1'b1;
        sample_ready = 1'b1;
        send_slot(1'b0, 18'h00000, SLOT - 9, 1'b0);
        send_slot(1'b1, 18'h30303, SLOT, 1'b1);
        report("en_ferr_end", 32'(frame_err), 32'd1);
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
